// File: rtl/gfx_pkg.sv
// Shared graphics types and constants for the pixel write path.
// Screen geometry, pixel record, write-queue FSM state and address helper.
package gfx_pkg;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned ADDR_W  = 19;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    localparam int unsigned PIXEL_W = $bits(pixel_t);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wq_state_e;

    // Linear address y*640 + x built from shifts (640 = 512 + 128)
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; power-of-two depth, pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_queue.sv
// Buffers drawer pixels, drops off-screen ones, and issues one framebuffer
// write per kept pixel over a req/ack handshake.
module pixel_write_queue
    import gfx_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               pix_valid_in,
    output logic               pix_ready_out,
    input  logic [COORD_W-1:0] pix_x_in,
    input  logic [COORD_W-1:0] pix_y_in,
    input  logic [COLOR_W-1:0] pix_color_in,
    output logic               fb_req_out,
    output logic [ADDR_W-1:0]  fb_addr_out,
    output logic [COLOR_W-1:0] fb_data_out,
    input  logic               fb_ack_in,
    output logic [15:0]        clipped_cnt_out,
    output logic               busy_out
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    pixel_t          in_pix;
    pixel_t          head;
    logic [CNT_W-1:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            in_range_c;
    logic            accept_c;
    logic            push_c;
    logic            clip_c;
    logic            pop_c;
    wq_state_e       state_q;
    wq_state_e       state_d;

    assign in_pix     = '{x: pix_x_in, y: pix_y_in, color: pix_color_in};
    assign in_range_c = (32'(pix_x_in) < H_RES) && (32'(pix_y_in) < V_RES);

    // Ready depends only on registered occupancy; no same-cycle pop bypass
    assign pix_ready_out = (fifo_count != CNT_W'(DEPTH));
    assign accept_c      = pix_valid_in & pix_ready_out;
    assign push_c        = pix_valid_in & ~fifo_full & in_range_c;
    assign clip_c        = accept_c & ~in_range_c;
    assign busy_out      = (fifo_count != '0) | fb_req_out;

    sync_fifo #(
        .WIDTH (PIXEL_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_),
        .push  (push_c),
        .wdata (in_pix),
        .pop   (pop_c),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = REQ;
            REQ:     if (fb_ack_in && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pop whenever the port is free: idle, or the current write is being acked
    always_comb begin
        pop_c = 1'b0;
        case (state_q)
            IDLE:    pop_c = !fifo_empty;
            REQ:     pop_c = fb_ack_in && !fifo_empty;
            default: pop_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            fb_req_out  <= 1'b0;
            fb_addr_out <= '0;
            fb_data_out <= '0;
        end else begin
            fb_req_out <= (state_d == REQ);
            if (pop_c) begin
                fb_addr_out <= pixel_addr(head.x, head.y);
                fb_data_out <= head.color;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            clipped_cnt_out <= '0;
        end else if (clip_c && (clipped_cnt_out != 16'hFFFF)) begin
            clipped_cnt_out <= clipped_cnt_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_write_queue.sv
// Self-checking bench for pixel_write_queue: vector table, corner sequences,
// and a write scoreboard fed at pixel acceptance.
module tb_pixel_write_queue;
    import gfx_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic               clk;
    logic               rst_;
    logic               pix_valid_in;
    logic               pix_ready_out;
    logic [COORD_W-1:0] pix_x_in;
    logic [COORD_W-1:0] pix_y_in;
    logic [COLOR_W-1:0] pix_color_in;
    logic               fb_req_out;
    logic [ADDR_W-1:0]  fb_addr_out;
    logic [COLOR_W-1:0] fb_data_out;
    logic               fb_ack_in;
    logic [15:0]        clipped_cnt_out;
    logic               busy_out;

    logic man_ack;
    logic rand_ack_en;
    logic rand_ack_val;
    int   ack_wait;

    int checks;
    int errors;
    int accepted;
    int writes;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int x;
        int y;
        int c;
        int exp_ready;
        int exp_clip;
    } vec_t;
    vec_t vecs[8];

    assign fb_ack_in = rand_ack_en ? rand_ack_val : man_ack;

    pixel_write_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_            (rst_),
        .pix_valid_in    (pix_valid_in),
        .pix_ready_out   (pix_ready_out),
        .pix_x_in        (pix_x_in),
        .pix_y_in        (pix_y_in),
        .pix_color_in    (pix_color_in),
        .fb_req_out      (fb_req_out),
        .fb_addr_out     (fb_addr_out),
        .fb_data_out     (fb_data_out),
        .fb_ack_in       (fb_ack_in),
        .clipped_cnt_out (clipped_cnt_out),
        .busy_out        (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: expected writes recorded on acceptance, compared on ack
    always @(posedge clk) begin
        wr_t e;
        if (!rst_) begin
            if (pix_valid_in && pix_ready_out) begin
                accepted++;
                if (pix_x_in < 640 && pix_y_in < 480) begin
                    e.addr = int'(pix_y_in) * 640 + int'(pix_x_in);
                    e.data = int'(pix_color_in);
                    exp_q.push_back(e);
                end
            end
            if (fb_req_out && fb_ack_in) begin
                writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d with no pending pixel", fb_addr_out);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", longint'(fb_addr_out), longint'(e.addr));
                    check("write_data", longint'(fb_data_out), longint'(e.data));
                end
            end
        end
    end

    // Random ack spacing of 0-3 idle cycles between acks
    always @(negedge clk) begin
        if (rand_ack_en) begin
            if (ack_wait == 0) begin
                rand_ack_val = 1'b1;
                ack_wait = int'($urandom_range(0, 3));
            end else begin
                rand_ack_val = 1'b0;
                ack_wait--;
            end
        end
    end

    // Offer a pixel for exactly one cycle, accepted or not
    task automatic offer(input int x, input int y, input int c);
        pix_x_in     = COORD_W'(x);
        pix_y_in     = COORD_W'(y);
        pix_color_in = COLOR_W'(c);
        pix_valid_in = 1'b1;
        @(negedge clk);
        pix_valid_in = 1'b0;
    endtask

    // Wait for ready (bounded) and then present the pixel for one cycle
    task automatic put(input int x, input int y, input int c);
        int n;
        n = 0;
        while (!pix_ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready_out) begin
            checks++;
            errors++;
            $display("FAIL put_timeout: ready stuck low for pixel %0d,%0d", x, y);
        end else begin
            offer(x, y, c);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_out && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, longint'(busy_out), 0);
        check({name, "_sb_empty"}, longint'(exp_q.size()), 0);
    endtask

    initial begin
        int acc0;
        int wr0;
        int run;
        int npts;
        int cx;
        int cy;
        int d;

        checks = 0;
        errors = 0;
        accepted = 0;
        writes = 0;
        ack_wait = 0;
        rand_ack_en = 1'b0;
        rand_ack_val = 1'b0;
        man_ack = 1'b0;
        pix_valid_in = 1'b0;
        pix_x_in = '0;
        pix_y_in = '0;
        pix_color_in = '0;
        rst_ = 1'b1;

        vecs[0] = '{639, 479, 8'hFF, 1, 0};
        vecs[1] = '{640,   0, 8'h01, 1, 1};
        vecs[2] = '{  0, 480, 8'h02, 1, 2};
        vecs[3] = '{  0,   0, 8'h11, 1, 2};
        vecs[4] = '{1023, 1023, 8'h22, 1, 3};
        vecs[5] = '{  5,   7, 8'h33, 1, 3};
        vecs[6] = '{639,   0, 8'h44, 1, 3};
        vecs[7] = '{  0, 479, 8'h55, 1, 3};

        repeat (2) @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        check("rst_ready",   longint'(pix_ready_out), 1);
        check("rst_req",     longint'(fb_req_out), 0);
        check("rst_addr",    longint'(fb_addr_out), 0);
        check("rst_data",    longint'(fb_data_out), 0);
        check("rst_clipped", longint'(clipped_cnt_out), 0);
        check("rst_busy",    longint'(busy_out), 0);

        // Single pixel latency with ack tied high
        man_ack = 1'b1;
        offer(100, 100, 8'h3C);
        check("t1_req_lag", longint'(fb_req_out), 0);
        check("t1_busy",    longint'(busy_out), 1);
        @(negedge clk);
        check("t1_req",  longint'(fb_req_out), 1);
        check("t1_addr", longint'(fb_addr_out), 64100);
        check("t1_data", longint'(fb_data_out), 8'h3C);
        @(negedge clk);
        check("t1_req_drop", longint'(fb_req_out), 0);
        check("t1_busy_drop", longint'(busy_out), 0);

        // Clipping table
        wr0 = writes;
        foreach (vecs[i]) begin
            check("vec_ready", longint'(pix_ready_out), longint'(vecs[i].exp_ready));
            offer(vecs[i].x, vecs[i].y, vecs[i].c);
            check("vec_clipped", longint'(clipped_cnt_out), longint'(vecs[i].exp_clip));
        end
        wait_idle("vec");
        check("vec_writes", longint'(writes - wr0), 5);

        // Backpressure: request held, FIFO fills to DEPTH
        man_ack = 1'b0;
        offer(10, 20, 8'h01);
        @(negedge clk);
        check("full_req_up", longint'(fb_req_out), 1);
        acc0 = accepted;
        for (int i = 0; i < 10; i++) begin
            offer(i * 3, 50, 8'h80 + i);
        end
        check("full_accepted", longint'(accepted - acc0), DEPTH);
        check("full_ready",    longint'(pix_ready_out), 0);
        check("full_addr_hold", longint'(fb_addr_out), 20 * 640 + 10);
        man_ack = 1'b1;
        run = 0;
        while (fb_req_out && run < 50) begin
            @(negedge clk);
            run++;
        end
        check("full_b2b_run", longint'(run), DEPTH + 1);
        wait_idle("full");

        // Simultaneous push and ack at count 3
        man_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(200 + i, 300, 8'h10 + i);
        end
        pix_x_in = COORD_W'(250);
        pix_y_in = COORD_W'(301);
        pix_color_in = 8'h77;
        pix_valid_in = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        pix_valid_in = 1'b0;
        man_ack = 1'b0;
        acc0 = accepted;
        for (int i = 0; i < 7; i++) begin
            offer(400 + i, 10, 8'h20 + i);
        end
        check("simul_room", longint'(accepted - acc0), DEPTH - 3);
        man_ack = 1'b1;
        wait_idle("simul");

        // Asynchronous reset while a write is pending with 5 queued
        man_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(30 + i, 40, 8'h90 + i);
        end
        check("mid_req_up", longint'(fb_req_out), 1);
        #2;
        rst_ = 1'b1;
        #1;
        check("arst_req",     longint'(fb_req_out), 0);
        check("arst_busy",    longint'(busy_out), 0);
        check("arst_ready",   longint'(pix_ready_out), 1);
        check("arst_addr",    longint'(fb_addr_out), 0);
        check("arst_clipped", longint'(clipped_cnt_out), 0);
        exp_q.delete();
        @(negedge clk);
        rst_ = 1'b0;
        check("post_rst_ready", longint'(pix_ready_out), 1);
        man_ack = 1'b1;
        wr0 = writes;
        offer(300, 200, 8'h5A);
        wait_idle("post_rst");
        check("post_rst_writes", longint'(writes - wr0), 1);

        // Midpoint circle r=10 at (100,100) with random ack delays
        man_ack = 1'b0;
        rand_ack_en = 1'b1;
        wr0 = writes;
        npts = 0;
        cx = 0;
        cy = 10;
        d = 1 - 10;
        while (cx <= cy) begin
            put(100 + cx, 100 + cy, 8'hA0); put(100 - cx, 100 + cy, 8'hA1);
            put(100 + cx, 100 - cy, 8'hA2); put(100 - cx, 100 - cy, 8'hA3);
            put(100 + cy, 100 + cx, 8'hA4); put(100 - cy, 100 + cx, 8'hA5);
            put(100 + cy, 100 - cx, 8'hA6); put(100 - cy, 100 - cx, 8'hA7);
            npts += 8;
            if (d < 0) begin
                d = d + 2 * cx + 3;
            end else begin
                d = d + 2 * (cx - cy) + 5;
                cy--;
            end
            cx++;
        end
        wait_idle("circle");
        check("circle_writes",  longint'(writes - wr0), longint'(npts));
        check("circle_clipped", longint'(clipped_cnt_out), 0);
        rand_ack_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
